// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

   localparam int unsigned ALU_DW = 32;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      AND = 2'd2,
      OR  = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter. ALU_ARB_RR_EN selects round-robin ties,
// otherwise requester 0 has fixed priority.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant,
   output logic any_valid
);

   assign any_valid = valid0 | valid1;

`ifdef ALU_ARB_RR_EN
   // On a tie, favour whoever did not win the previous accept
   assign grant = (valid0 && valid1) ? ~last_grant : valid1;
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant = ~valid0 & valid1;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, returning tagged results.
// Optional ALU_ARB_RR_EN enables round-robin tie-breaking in rr_arb2.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DW = ALU_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic [1:0]    req0_op,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic [1:0]    req1_op,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [DW-1:0] rsp_data,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [1:0]    alu_op,
   output logic          alu_ena,
   input  logic [DW-1:0] alu_ans
);

   arb_state_e    state_q, state_d;
   logic          grant, any_valid, accept, last_grant;
   logic [DW-1:0] a_q, b_q, rsp_data_q;
   alu_op_e       op_q;
   logic          id_q, rsp_id_q;

`ifdef ALU_ARB_RR_EN
   logic last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= grant;
      end
   end

   assign last_grant = last_grant_q;
`else
   assign last_grant = 1'b0;
`endif

   rr_arb2 u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .any_valid  (any_valid)
   );

   always_comb begin
      state_d    = state_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      alu_ena    = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            req0_ready = req0_valid & ~grant;
            req1_ready = req1_valid & grant;
            accept     = any_valid;
            if (any_valid) state_d = ISSUE;
         end
         ISSUE: begin
            alu_ena = 1'b1;
            state_d = WAIT;
         end
         WAIT: state_d = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= ADD;
         id_q       <= 1'b0;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q  <= grant ? req1_a : req0_a;
            b_q  <= grant ? req1_b : req0_b;
            op_q <= alu_op_e'(grant ? req1_op : req0_op);
            id_q <= grant;
         end
         // ALU result becomes valid one edge after the enable cycle
         if (state_q == WAIT) begin
            rsp_data_q <= alu_ans;
            rsp_id_q   <= id_q;
         end
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = op_q;
   assign rsp_data = rsp_data_q;
   assign rsp_id   = rsp_id_q;

endmodule
